// File: rtl/tick_pkg.sv
// Tick generator package.
// Holds the mode encoding and the default parameter values used by the
// tick_generator top and its per-channel divider.
package tick_pkg;
    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_CNT_W  = 28;
    localparam int unsigned DEF_DIV    = 65000000;
endpackage

// File: rtl/tick_generator_if.sv
// Tick generator signal bundle.
// Groups the per-channel control inputs and the tick outputs so a driver
// (master) and the generator side (slave) can share one handle.
//   en, mode, load, sync, div_val : control toward the generator
//   tick, clk_out, upd_ack         : generator results
interface tick_generator_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 28
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH*CNT_W-1:0] div_val;
    logic [NUM_CH-1:0]       load;
    logic                    sync;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       upd_ack;

    modport master (output en, mode, div_val, load, sync,
                    input  tick, clk_out, upd_ack);
    modport slave  (input  en, mode, div_val, load, sync,
                    output tick, clk_out, upd_ack);
endinterface

// File: rtl/tick_channel.sv
// One divider channel.
// Counts 0..div_q, pulsing tick on the wrap edge; clk_out either follows
// tick (pulse mode) or flips on each wrap (toggle mode). A newly loaded
// divisor waits in pend_q until the period boundary so periods never tear.
//   clk_in, rst_n          : clock, async active-low reset
//   en, mode, load, sync   : count enable, output mode, divisor capture, restart
//   div_val                : divisor to capture on load
//   tick, clk_out, upd_ack : registered outputs
module tick_channel
    import tick_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic             sync,
    input  logic [CNT_W-1:0] div_val,
    output logic             tick,
    output logic             clk_out,
    output logic             upd_ack
);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             tick_q, tick_d, clk_out_q, clk_out_d, ack_q, ack_d;
    logic             wrap;

    // ">=" rather than "==": a divisor applied while disabled may be smaller
    // than the held count, and this folds that case into an ordinary wrap.
    assign wrap = (cnt_q >= div_q);

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;
        ack_d     = 1'b0;
        if (sync) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (load) begin
                div_d    = div_val;
                pend_v_d = 1'b0;
                ack_d    = 1'b1;
            end else if (pend_v_q) begin
                div_d    = pend_q;
                pend_v_d = 1'b0;
                ack_d    = 1'b1;
            end
        end else begin
            if (en) begin
                if (wrap) begin
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    clk_out_d = (mode == MODE_TOGGLE) ? ~clk_out_q : 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    clk_out_d = (mode == MODE_TOGGLE) ? clk_out_q : 1'b0;
                end
            end
            // Pending divisor swaps in at the period boundary, or at once
            // when the channel is idle.
            if (pend_v_q && (!en || wrap)) begin
                div_d    = pend_q;
                pend_v_d = 1'b0;
                ack_d    = 1'b1;
            end
            // A load on the same edge stays pending for the next boundary.
            if (load) begin
                pend_d   = div_val;
                pend_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= RST_DIV;
            pend_q    <= RST_DIV;
            pend_v_q  <= 1'b0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            ack_q     <= ack_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;
    assign upd_ack = ack_q;
endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick generator.
// NUM_CH independent programmable dividers sharing one clock and one
// phase-restart (sync) input. Per-channel buses are sliced here and every
// channel's behaviour lives in tick_channel.
//   clk_in, rst_n          : clock, async active-low reset
//   en, mode, load         : per-channel enable, mode (0 pulse, 1 toggle), load
//   div_val                : per-channel divisor, channel k at [k*CNT_W +: CNT_W]
//   sync                   : restart all channels
//   tick, clk_out, upd_ack : per-channel registered outputs
module tick_generator
    import tick_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       upd_ack
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .en     (en[g]),
            .mode   (mode[g]),
            .load   (load[g]),
            .sync   (sync),
            .div_val(div_val[g*CNT_W +: CNT_W]),
            .tick   (tick[g]),
            .clk_out(clk_out[g]),
            .upd_ack(upd_ack[g])
        );
    end
endmodule

// File: tb/tb_tick_generator.sv
module tb_tick_generator;
    localparam int NCH = 2;
    localparam int CW  = 8;

    typedef struct {
        int         ph;
        int         idx;
        logic [5:0] v;   // {tick[1:0], clk_out[1:0], upd_ack[1:0]}
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    tick_generator_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    tick_generator #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(3)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (bus.en),
        .mode   (bus.mode),
        .div_val(bus.div_val),
        .load   (bus.load),
        .sync   (bus.sync),
        .tick   (bus.tick),
        .clk_out(bus.clk_out),
        .upd_ack(bus.upd_ack)
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   phase = 0;
    int   vidx  = 0;

    // Scoreboard monitor: one expectation is consumed per falling edge.
    initial begin
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.tick, bus.clk_out, bus.upd_ack};
                n_vec++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL ph%0d vec%0d tick/clk_out/upd_ack got %b_%b_%b want %b_%b_%b",
                             e.ph, e.idx, got[5:4], got[3:2], got[1:0],
                             e.v[5:4], e.v[3:2], e.v[1:0]);
                end
            end
        end
    end

    task automatic push(input logic [1:0] t, input logic [1:0] c, input logic [1:0] a);
        exp_t e;
        e.ph  = phase;
        e.idx = vidx;
        e.v   = {t, c, a};
        exp_q.push_back(e);
        vidx++;
    endtask

    // Advance one clock edge and record what the outputs must show after it.
    task automatic cyc(input logic [1:0] t, input logic [1:0] c, input logic [1:0] a);
        @(posedge clk_in);
        #1;
        push(t, c, a);
    endtask

    initial begin
        logic b;
        bus.en      = '0;
        bus.mode    = '0;
        bus.load    = '0;
        bus.sync    = 1'b0;
        bus.div_val = '0;

        // Reset state
        phase = 0;
        #1 push(2'b00, 2'b00, 2'b00);
        #11 rst_n = 1'b1;

        // Channel 0 pulse mode, default divisor 3: ticks after edges 4, 8, 12
        phase = 1;
        bus.en = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            b = (k % 4 == 0);
            cyc({1'b0, b}, {1'b0, b}, 2'b00);
        end

        bus.sync = 1'b1;
        cyc(2'b00, 2'b00, 2'b00);
        bus.sync = 1'b0;

        // Channel 1 toggle, divisor 1 loaded while idle: ack once, 2 high / 2 low
        phase = 2;
        bus.en = 2'b00; bus.mode = 2'b10;
        bus.div_val = {8'd1, 8'd0}; bus.load = 2'b10;
        cyc(2'b00, 2'b00, 2'b00);
        bus.load = 2'b00;
        cyc(2'b00, 2'b00, 2'b10);
        bus.en = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            cyc({(k % 2 == 0), 1'b0}, {(k % 4 == 2) || (k % 4 == 3), 1'b0}, 2'b00);
        end

        // Channel 0: load 9 mid-period; old period finishes, then every 10
        phase = 3;
        bus.en = 2'b01;
        for (int k = 1; k <= 24; k++) begin
            b = (k == 4) || (k == 14) || (k == 24);
            cyc({1'b0, b}, {1'b0, b}, {1'b0, k == 4});
            if (k == 1) begin bus.div_val = {8'd0, 8'd9}; bus.load = 2'b01; end
            if (k == 2) bus.load = 2'b00;
        end

        bus.sync = 1'b1;
        cyc(2'b00, 2'b00, 2'b00);
        bus.sync = 1'b0;

        // Channel 1 divisor 0: tick every cycle, toggle flips every cycle
        phase = 4;
        bus.en = 2'b00; bus.div_val = {8'd0, 8'd0}; bus.load = 2'b10;
        cyc(2'b00, 2'b00, 2'b00);
        bus.load = 2'b00;
        cyc(2'b00, 2'b00, 2'b10);
        bus.en = 2'b10;
        for (int k = 1; k <= 6; k++) cyc(2'b10, {k % 2 == 1, 1'b0}, 2'b00);
        // Switch to pulse mode: effective on the next edge
        bus.mode = 2'b00;
        cyc(2'b10, 2'b10, 2'b00);
        cyc(2'b10, 2'b10, 2'b00);

        // load together with sync applies immediately; sync re-aligns phases
        phase = 5;
        bus.sync = 1'b1; bus.load = 2'b11; bus.div_val = {8'd2, 8'd4};
        bus.en = 2'b11; bus.mode = 2'b11;
        cyc(2'b00, 2'b00, 2'b11);
        bus.sync = 1'b0; bus.load = 2'b00;
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 7; k++) begin
                cyc({(k == 3) || (k == 6), k == 5},
                    {(k >= 3) && (k < 6), k >= 5}, 2'b00);
            end
            if (r == 0) begin
                bus.sync = 1'b1;
                cyc(2'b00, 2'b00, 2'b00);
                bus.sync = 1'b0;
            end
        end

        // Asynchronous reset between edges, then default divisor 3 restored
        phase = 6;
        @(posedge clk_in);
        #1;
        rst_n = 1'b0;
        push(2'b00, 2'b00, 2'b00);
        bus.en = 2'b01; bus.mode = 2'b00;
        @(negedge clk_in);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            b = (k % 4 == 0);
            cyc({1'b0, b}, {1'b0, b}, 2'b00);
        end

        @(negedge clk_in);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending expectations got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
